handshake_rr_arbiter: RTL and testbench

HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

---
 rtl/handshake_rr_arbiter.sv | 119 +++++++++++
 tb/tb_handshake_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: round-robin arbiter that grants one of NREQ
// valid/ready requesters to a shared receiver for up to BURST beats.
// Each burst ends with one idle arbitration cycle.
module handshake_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(NREQ)-1:0]  out_src,
    output logic [NREQ-1:0]          grant
);

    localparam int         SW      = $clog2(NREQ);
    localparam logic [7:0] BURST_L = 8'(BURST);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [SW-1:0]   gidx_q;
    logic [SW-1:0]   last_q;
    logic [7:0]      beat_q;
    logic [7:0]      beat_d;

    logic            pick_found;
    logic [SW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            busy;
    logic            g_valid;

    assign busy    = (state_q == BUSY);
    assign g_valid = req_valid[gidx_q];
    assign beat_d  = beat_q + 8'd1;
    assign pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;

    // Round-robin pick: first valid above last, otherwise wrap to the lowest valid.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid[i] && (SW'(i) > last_q)) begin
                pick_found = 1'b1;
                pick_idx   = SW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = SW'(i);
            end
        end
    end

    // Data mux from the granted requester onto the shared channel.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (SW'(i) == gidx_q) out_data = req_data[i*DW +: DW];
        end
    end

    // Handshake outputs are combinational through the registered grant.
    always_comb begin
        out_valid = busy && g_valid;
        out_src   = gidx_q;
        grant     = grant_q;
        req_ready = busy ? ({{(NREQ-1){1'b0}}, out_ready} << gidx_q) : '0;
    end

    // Arbitration FSM: IDLE picks a winner, BUSY holds it until the burst
    // completes or the winner drops valid; last records who was served.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            beat_q  <= '0;
            last_q  <= SW'(NREQ-1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= BUSY;
                        grant_q <= pick_oh;
                        gidx_q  <= pick_idx;
                        beat_q  <= '0;
                    end
                end
                BUSY: begin
                    if (!g_valid) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= gidx_q;
                    end else if (out_ready) begin
                        beat_q <= beat_d;
                        if (beat_d == BURST_L) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            last_q  <= gidx_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter (NREQ=4, DW=8, BURST=4).
module tb_handshake_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [3:0]  grant;

    int nvec = 0;
    int nmis = 0;

    handshake_rr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic [3:0] g;
        logic       ov;
        logic [1:0] src;
        logic [7:0] dat;
        logic [3:0] rr;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, let combinational paths settle.
    task automatic drive(input logic [3:0] v, input logic rdy);
        @(negedge clk);
        req_valid = v;
        out_ready = rdy;
        #1;
    endtask

    task automatic check_out(input string nm, input logic [3:0] g, input logic ov,
                             input logic [1:0] src, input logic [7:0] dat, input logic [3:0] rr);
        chk({nm, ".grant"}, 32'(grant), 32'(g));
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, ".req_ready"}, 32'(req_ready), 32'(rr));
        if (ov) begin
            chk({nm, ".out_src"}, 32'(out_src), 32'(src));
            chk({nm, ".out_data"}, 32'(out_data), 32'(dat));
        end
    endtask

    // One reset edge with all requests low, then confirm the idle outputs.
    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out({nm, ".reset"}, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_data  = 32'h13121110;
        out_ready = 1'b0;

        // All four requesting: 0,1,2,3,0 with 4 beats each and one idle cycle between.
        for (int c = 0; c < 22; c++) begin
            int r;
            r = (c / 5) % 4;
            tbl[c].v   = 4'b1111;
            tbl[c].rdy = 1'b1;
            if (c % 5 == 0) begin
                tbl[c].g = 4'b0000; tbl[c].ov = 1'b0; tbl[c].src = 2'd0;
                tbl[c].dat = 8'h00; tbl[c].rr = 4'b0000;
            end else begin
                tbl[c].g   = 4'b0001 << r;
                tbl[c].ov  = 1'b1;
                tbl[c].src = 2'(r);
                tbl[c].dat = 8'h10 + 8'(r);
                tbl[c].rr  = 4'b0001 << r;
            end
        end

        do_reset("init");
        for (int c = 0; c < 22; c++) begin
            drive(tbl[c].v, tbl[c].rdy);
            check_out($sformatf("rr_all[%0d]", c), tbl[c].g, tbl[c].ov,
                      tbl[c].src, tbl[c].dat, tbl[c].rr);
        end

        // Lone requester 2 with data A5.
        do_reset("lone2");
        req_data = 32'h00A50000;
        drive(4'b0100, 1'b1);
        check_out("lone2.c0", 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000);
        drive(4'b0100, 1'b1);
        check_out("lone2.c1", 4'b0100, 1'b1, 2'd2, 8'hA5, 4'b0100);

        // Requester 1 drops valid after 2 beats; next search starts at 2.
        do_reset("early");
        req_data = 32'h13121110;
        drive(4'b0010, 1'b1);
        drive(4'b0010, 1'b1);
        check_out("early.b0", 4'b0010, 1'b1, 2'd1, 8'h11, 4'b0010);
        drive(4'b0010, 1'b1);
        check_out("early.b1", 4'b0010, 1'b1, 2'd1, 8'h11, 4'b0010);
        drive(4'b0100, 1'b1);
        check_out("early.drop", 4'b0010, 1'b0, 2'd1, 8'h11, 4'b0010);
        drive(4'b0101, 1'b1);
        check_out("early.idle", 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000);
        drive(4'b0101, 1'b1);
        check_out("early.next", 4'b0100, 1'b1, 2'd2, 8'h12, 4'b0100);

        // Stall for 5 cycles mid-burst: nothing moves, no beats counted.
        do_reset("stall");
        req_data = 32'h0000003C;
        drive(4'b0001, 1'b1);
        drive(4'b0001, 1'b1);
        drive(4'b0001, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 1'b0);
            check_out($sformatf("stall.s%0d", k), 4'b0001, 1'b1, 2'd0, 8'h3C, 4'b0000);
        end
        drive(4'b0001, 1'b1);
        check_out("stall.b2", 4'b0001, 1'b1, 2'd0, 8'h3C, 4'b0001);
        drive(4'b0001, 1'b1);
        check_out("stall.b3", 4'b0001, 1'b1, 2'd0, 8'h3C, 4'b0001);
        drive(4'b0001, 1'b1);
        check_out("stall.done", 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000);

        // Reset pulse after beat 2 of requester 3; requester 0 wins afterwards.
        do_reset("midrst");
        req_data = 32'h13121110;
        drive(4'b1000, 1'b1);
        drive(4'b1000, 1'b1);
        check_out("midrst.b0", 4'b1000, 1'b1, 2'd3, 8'h13, 4'b1000);
        drive(4'b1000, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1001;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("midrst.after", 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000);
        drive(4'b1001, 1'b1);
        check_out("midrst.rearb", 4'b0001, 1'b1, 2'd0, 8'h10, 4'b0001);

        // Requester 0 waits while 1 holds the grant.
        do_reset("hold");
        drive(4'b0010, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0011, 1'b1);
            check_out($sformatf("hold.b%0d", k), 4'b0010, 1'b1, 2'd1, 8'h11, 4'b0010);
        end
        drive(4'b0011, 1'b1);
        check_out("hold.idle", 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000);
        drive(4'b0011, 1'b1);
        check_out("hold.next", 4'b0001, 1'b1, 2'd0, 8'h10, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
